io_intr_unit: RTL and testbench
===============================

Name: io_intr_unit

Overview:
- Parametrised successor to the single-channel INPR/OUTR/FGI/FGO/IEN arrangement of the basic computer.
- Owns CHANNELS independent input and output device channels, each with its own data register and flag flip-flops.
- Adds device-side valid/ready handshakes, the IEN flip-flop and the interrupt request flip-flop R with channel identification.
- Sits between external devices and the control unit; serves INP/OUT/SKI/SKO/ION/IOF and interrupt-cycle entry.

Parameters:
- DATA_W, 8: width of each INPR/OUTR.
- CHANNELS, 2: number of I/O channel pairs; range 1..8.
- CH_W, 3: width of channel-select and channel-id fields; must satisfy 2**CH_W >= CHANNELS.

Ports:
- clk  in  1: single system clock; all state changes on its rising edge.
- reset  in  1: synchronous, active-high reset.
- dev_in_data  in  CHANNELS*DATA_W: input character per channel; channel k occupies bits [k*DATA_W +: DATA_W].
- dev_in_valid  in  CHANNELS: device offers a character.
- dev_in_ready  out  CHANNELS: equals ~FGI[k].
- dev_out_data  out  CHANNELS*DATA_W: OUTR contents per channel.
- dev_out_valid  out  CHANNELS: equals ~FGO[k].
- dev_out_ack  in  CHANNELS: device consumed the OUTR character.
- sel  in  CH_W: channel addressed by the CPU instruction.
- cpu_inp  in  1: INP executing.
- cpu_out  in  1: OUT executing.
- cpu_ski  in  1: SKI executing.
- cpu_sko  in  1: SKO executing.
- cpu_ion  in  1: ION executing.
- cpu_iof  in  1: IOF executing.
- cpu_wdata  in  DATA_W: AC low bits for OUT.
- eval_r  in  1: high in T0..T2 of non-interrupt cycles; R may be set only while eval_r is high.
- r_ack  in  1: RT2 of the interrupt cycle.
- inpr_rdata  out  DATA_W: INPR[sel], combinational.
- skip  out  1: combinational, (cpu_ski & FGI[sel]) | (cpu_sko & FGO[sel]).
- ien  out  1: IEN flip-flop.
- r_flag  out  1: R flip-flop.
- irq_chan  out  CH_W: channel id latched when R sets.
- irq_is_out  out  1: 1 if the latched cause is an FGO flag, 0 if it is an FGI flag.

Behaviour:
- Reset values:
  - FGI = 0, FGO = all ones (output registers empty).
  - INPR = 0, OUTR = 0.
  - IEN = 0, R = 0, irq_chan = 0, irq_is_out = 0.
  - Consequently dev_in_ready = all ones and dev_out_valid = 0.
- Reset mid-operation discards any pending character or request. Reset has priority over every other input.
- Input handshake, per channel k:
  - When dev_in_valid[k] & dev_in_ready[k]: INPR[k] <= data and FGI[k] <= 1 at the next edge.
  - While FGI[k] = 1, dev_in_valid[k] is ignored and the old data is kept.
- INP: when cpu_inp, FGI[sel] <= 0 at the next edge. inpr_rdata is valid in the same cycle.
- INP and input capture in the same cycle: the CPU clear wins only if FGI was already 1. Since ready is 0 in that case, no conflict can arise.
- OUT:
  - When cpu_out: OUTR[sel] <= cpu_wdata and FGO[sel] <= 0.
  - The CPU issues OUT only after SKO reports FGO = 1. OUT while FGO = 0 still overwrites OUTR and keeps FGO at 0.
- Output handshake: when dev_out_ack[k] & dev_out_valid[k], FGO[k] <= 1. An ack while valid = 0 is ignored.
- OUT to channel k together with an ack on channel k in the same cycle: OUT wins, so FGO[k] = 0 and the new data is held.
- sel >= CHANNELS: INP, OUT, SKI and SKO are no-ops; inpr_rdata = 0; skip = 0.
- IEN control:
  - cpu_ion sets IEN; cpu_iof clears IEN.
  - Both asserted in the same cycle: IEN cleared (IOF wins).
  - r_ack clears IEN.
- R set rule: when eval_r & IEN & ~R & any(FGI | FGO), at the next edge:
  - R <= 1.
  - irq_chan/irq_is_out latch the winning flag.
  - Default priority: lowest channel index first; within a channel, FGI before FGO.
  - irq_chan and irq_is_out hold until the next set.
- R clear rule: r_ack sets R <= 0. If r_ack and the set condition coincide, r_ack wins and R = 0.
- Flag clearing is left to software via INP/OUT; R does not clear flags.
- Latency:
  - Device strobe to FGI visible: 1 cycle.
  - FGI to R: 1 cycle after the first eval_r cycle with IEN = 1.

Optional Feature:
- Macro: IO_INTR_RR_ARB_EN.
- When defined:
  - Arbitration among the 2*CHANNELS flag sources is round-robin.
  - The search starts at the source after the last granted one. Source order is FGI0, FGO0, FGI1, FGO1, and so on.
  - A last-grant pointer is reset to the final source, so the first grant after reset is FGI0.
  - The pointer updates only when R sets.
- When undefined: fixed priority as described in Behaviour, and no pointer register is present.

Test Plan:
- Reset:
  - Stimulus: pulse reset for 1 cycle.
  - Response: FGO = 2'b11, FGI = 0, dev_out_valid = 0, dev_in_ready = 2'b11, ien = 0, r_flag = 0.
- Input channel capture and clear:
  - Stimulus: dev_in_data ch1 = 8'h41 with dev_in_valid[1] for 1 cycle.
  - Response: FGI[1] = 1 and dev_in_ready[1] = 0 next cycle.
  - Then sel = 1, cpu_ski gives skip = 1; cpu_inp gives inpr_rdata = 8'h41, and FGI[1] = 0 afterwards.
- Output channel:
  - Stimulus: sel = 0, cpu_out, cpu_wdata = 8'h5A.
  - Response: dev_out_valid[0] = 1 with dev_out_data ch0 = 8'h5A; SKO gives skip = 0.
  - Then dev_out_ack[0] gives FGO[0] = 1 next cycle and dev_out_valid[0] = 0.
- Interrupt entry:
  - Stimulus: cpu_ion, then FGI[1] set, then eval_r.
  - Response: r_flag = 1, irq_chan = 1, irq_is_out = 0.
  - Then r_ack gives r_flag = 0 and ien = 0.
  - Also: eval_r with ien = 0 leaves r_flag = 0.
- Simultaneous events:
  - cpu_ion & cpu_iof gives ien = 0.
  - r_ack coincident with the set condition gives r_flag = 0.
  - OUT plus ack on the same channel gives FGO = 0 holding the new data.
- Priority:
  - Stimulus: FGO0 and FGI1 both pending, with eval_r, repeated across two grant/ack rounds.
  - Fixed priority: irq_chan = 0 with irq_is_out = 1 (FGO0) on both rounds.
  - With IO_INTR_RR_ARB_EN: the second grant after r_ack is channel 1 with irq_is_out = 0 (FGI1).

Source files
------------

// File: rtl/io_intr_unit.sv
// Multi-channel I/O flag unit with IEN/R interrupt request and channel identification.
// Optional macro IO_INTR_RR_ARB_EN selects round-robin instead of fixed-priority flag arbitration.
module io_intr_unit #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS*DATA_W-1:0] dev_in_data,
  input  logic [CHANNELS-1:0]        dev_in_valid,
  output logic [CHANNELS-1:0]        dev_in_ready,
  output logic [CHANNELS*DATA_W-1:0] dev_out_data,
  output logic [CHANNELS-1:0]        dev_out_valid,
  input  logic [CHANNELS-1:0]        dev_out_ack,
  input  logic [CH_W-1:0]            sel,
  input  logic                       cpu_inp,
  input  logic                       cpu_out,
  input  logic                       cpu_ski,
  input  logic                       cpu_sko,
  input  logic                       cpu_ion,
  input  logic                       cpu_iof,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       eval_r,
  input  logic                       r_ack,
  output logic [DATA_W-1:0]          inpr_rdata,
  output logic                       skip,
  output logic                       ien,
  output logic                       r_flag,
  output logic [CH_W-1:0]            irq_chan,
  output logic                       irq_is_out
);

  localparam int NSRC  = 2 * CHANNELS;
  localparam int SRC_W = CH_W + 1;

  logic [CHANNELS-1:0] r_fgi;
  logic [CHANNELS-1:0] r_fgo;
  logic [DATA_W-1:0]   r_inpr [CHANNELS];
  logic [DATA_W-1:0]   r_outr [CHANNELS];
  logic                r_ien;
  logic                r_r;
  logic [CH_W-1:0]     r_irq_chan;
  logic                r_irq_is_out;

  logic [CHANNELS-1:0] w_sel_hit;
  logic [NSRC-1:0]     w_src;
  logic [SRC_W-1:0]    w_grant;
  logic                w_set;
  logic                w_r_sets;

  // A select outside the channel range hits nothing, so every CPU access becomes a no-op.
  always_comb begin
    w_sel_hit  = '0;
    inpr_rdata = '0;
    skip       = 1'b0;
    w_src      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == CH_W'(k)) w_sel_hit[k] = 1'b1;
      if (w_sel_hit[k]) begin
        inpr_rdata = r_inpr[k];
        skip       = (cpu_ski & r_fgi[k]) | (cpu_sko & r_fgo[k]);
      end
      w_src[2*k]   = r_fgi[k];
      w_src[2*k+1] = r_fgo[k];
    end
  end

`ifdef IO_INTR_RR_ARB_EN
  logic [SRC_W-1:0] r_last;
  int               w_best;
  int               w_dist;

  // Pick the pending source at the smallest circular distance after the last grant.
  always_comb begin
    w_grant = '0;
    w_best  = NSRC;
    w_dist  = 0;
    for (int i = 0; i < NSRC; i++) begin
      w_dist = (i + NSRC - 1 - int'(r_last)) % NSRC;
      if (w_src[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_grant = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_last <= SRC_W'(NSRC - 1);
    else if (w_r_sets) r_last <= w_grant;
  end
`else
  always_comb begin
    w_grant = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_src[i]) w_grant = SRC_W'(i);
    end
  end
`endif

  assign w_set    = eval_r & r_ien & ~r_r & (|w_src);
  assign w_r_sets = w_set & ~r_ack;

  // A flag that is already set blocks capture, so INP clear and capture never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fgi <= '0;
      r_fgo <= '1;
      for (int k = 0; k < CHANNELS; k++) begin
        r_inpr[k] <= '0;
        r_outr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (r_fgi[k]) begin
          if (cpu_inp && w_sel_hit[k]) r_fgi[k] <= 1'b0;
        end else if (dev_in_valid[k]) begin
          r_inpr[k] <= dev_in_data[k*DATA_W +: DATA_W];
          r_fgi[k]  <= 1'b1;
        end
        if (cpu_out && w_sel_hit[k]) begin
          r_outr[k] <= cpu_wdata;
          r_fgo[k]  <= 1'b0;
        end else if (dev_out_ack[k] && !r_fgo[k]) begin
          r_fgo[k] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ien        <= 1'b0;
      r_r          <= 1'b0;
      r_irq_chan   <= '0;
      r_irq_is_out <= 1'b0;
    end else begin
      if (cpu_iof || r_ack) r_ien <= 1'b0;
      else if (cpu_ion)     r_ien <= 1'b1;
      if (r_ack) begin
        r_r <= 1'b0;
      end else if (w_set) begin
        r_r          <= 1'b1;
        r_irq_chan   <= w_grant[SRC_W-1:1];
        r_irq_is_out <= w_grant[0];
      end
    end
  end

  always_comb begin
    dev_out_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      dev_out_data[k*DATA_W +: DATA_W] = r_outr[k];
    end
  end

  assign dev_in_ready  = ~r_fgi;
  assign dev_out_valid = ~r_fgo;
  assign ien           = r_ien;
  assign r_flag        = r_r;
  assign irq_chan      = r_irq_chan;
  assign irq_is_out    = r_irq_is_out;

endmodule

// File: tb/tb_io_intr_unit.sv
// Self-checking bench for io_intr_unit: directed scenarios plus random traffic against a
// behavioural flag/interrupt model (honours IO_INTR_RR_ARB_EN when defined).
module tb_io_intr_unit;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int CW = 3;
  localparam int NS = 2 * CH;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*DW-1:0] dev_in_data;
  logic [CH-1:0]   dev_in_valid;
  logic [CH-1:0]   dev_in_ready;
  logic [CH*DW-1:0] dev_out_data;
  logic [CH-1:0]   dev_out_valid;
  logic [CH-1:0]   dev_out_ack;
  logic [CW-1:0]   sel;
  logic            cpu_inp, cpu_out, cpu_ski, cpu_sko, cpu_ion, cpu_iof;
  logic [DW-1:0]   cpu_wdata;
  logic            eval_r, r_ack;
  logic [DW-1:0]   inpr_rdata;
  logic            skip, ien, r_flag, irq_is_out;
  logic [CW-1:0]   irq_chan;

  io_intr_unit #(.DATA_W(DW), .CHANNELS(CH), .CH_W(CW)) dut (
    .clk(clk), .reset(reset),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ack(dev_out_ack),
    .sel(sel), .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ski(cpu_ski), .cpu_sko(cpu_sko),
    .cpu_ion(cpu_ion), .cpu_iof(cpu_iof), .cpu_wdata(cpu_wdata),
    .eval_r(eval_r), .r_ack(r_ack), .inpr_rdata(inpr_rdata), .skip(skip),
    .ien(ien), .r_flag(r_flag), .irq_chan(irq_chan), .irq_is_out(irq_is_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: one entry per flag, sources ordered FGI0, FGO0, FGI1, FGO1, ...
  bit            m_fgi [CH];
  bit            m_fgo [CH];
  logic [DW-1:0] m_inpr [CH];
  logic [DW-1:0] m_outr [CH];
  bit            m_ien, m_r, m_isout, m_init;
  int            m_chan, m_ptr;
  logic          obs_skip;
  logic [DW-1:0] obs_rdata;

  function automatic bit src_pending(int src);
    return (src % 2 == 1) ? m_fgo[src/2] : m_fgi[src/2];
  endfunction

  task automatic model_clock();
    int s, start, win;
    bit any, set;
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        m_fgi[k] = 0; m_fgo[k] = 1; m_inpr[k] = '0; m_outr[k] = '0;
      end
      m_ien = 0; m_r = 0; m_chan = 0; m_isout = 0; m_ptr = NS - 1; m_init = 1;
      return;
    end
    s   = int'(sel);
    any = 0;
    for (int src = 0; src < NS; src++) any |= src_pending(src);
    set = eval_r && m_ien && !m_r && any;
`ifdef IO_INTR_RR_ARB_EN
    start = (m_ptr + 1) % NS;
`else
    start = 0;
`endif
    win = -1;
    for (int j = 0; j < NS; j++) begin
      if (win < 0 && src_pending((start + j) % NS)) win = (start + j) % NS;
    end
    for (int k = 0; k < CH; k++) begin
      if (!m_fgi[k] && dev_in_valid[k]) begin
        m_inpr[k] = dev_in_data[k*DW +: DW];
        m_fgi[k]  = 1;
      end else if (m_fgi[k] && cpu_inp && s == k) begin
        m_fgi[k] = 0;
      end
      if (cpu_out && s == k) begin
        m_outr[k] = cpu_wdata;
        m_fgo[k]  = 0;
      end else if (dev_out_ack[k]) begin
        m_fgo[k] = 1;
      end
    end
    if (cpu_iof || r_ack) m_ien = 0;
    else if (cpu_ion)     m_ien = 1;
    if (r_ack) m_r = 0;
    else if (set) begin
      m_r = 1; m_chan = win / 2; m_isout = (win % 2 == 1); m_ptr = win;
    end
  endtask

  task automatic idle();
    reset = 0; dev_in_data = '0; dev_in_valid = '0; dev_out_ack = '0; sel = '0;
    cpu_inp = 0; cpu_out = 0; cpu_ski = 0; cpu_sko = 0; cpu_ion = 0; cpu_iof = 0;
    cpu_wdata = '0; eval_r = 0; r_ack = 0;
  endtask

  task automatic cycle();
    logic [DW-1:0]    e_rd;
    logic             e_skip;
    logic [CH-1:0]    e_rdy, e_vld;
    logic [CH*DW-1:0] e_od;
    @(negedge clk);
    if (m_init && !reset) begin
      e_rd = '0; e_skip = 0;
      if (int'(sel) < CH) begin
        e_rd   = m_inpr[int'(sel)];
        e_skip = (cpu_ski && m_fgi[int'(sel)]) || (cpu_sko && m_fgo[int'(sel)]);
      end
      chk("skip", 64'(skip), 64'(e_skip));
      chk("inpr_rdata", 64'(inpr_rdata), 64'(e_rd));
    end
    obs_skip  = skip;
    obs_rdata = inpr_rdata;
    model_clock();
    @(posedge clk);
    #1;
    if (m_init) begin
      for (int k = 0; k < CH; k++) begin
        e_rdy[k] = !m_fgi[k];
        e_vld[k] = !m_fgo[k];
        e_od[k*DW +: DW] = m_outr[k];
      end
      chk("dev_in_ready", 64'(dev_in_ready), 64'(e_rdy));
      chk("dev_out_valid", 64'(dev_out_valid), 64'(e_vld));
      chk("dev_out_data", 64'(dev_out_data), 64'(e_od));
      chk("ien", 64'(ien), 64'(m_ien));
      chk("r_flag", 64'(r_flag), 64'(m_r));
      chk("irq_chan", 64'(irq_chan), 64'(m_chan));
      chk("irq_is_out", 64'(irq_is_out), 64'(m_isout));
    end
    idle();
  endtask

  task automatic do_out(input int ch, input logic [DW-1:0] d);
    sel = CW'(ch); cpu_out = 1; cpu_wdata = d; cycle();
  endtask

  task automatic do_in(input int ch, input logic [DW-1:0] d);
    dev_in_data[ch*DW +: DW] = d; dev_in_valid[ch] = 1; cycle();
  endtask

  initial begin
    m_init = 0;
    idle();
    reset = 1; cycle();
    chk("rst_in_ready", 64'(dev_in_ready), 64'h3);
    chk("rst_out_valid", 64'(dev_out_valid), 64'h0);
    chk("rst_ien", 64'(ien), 64'h0);
    chk("rst_r_flag", 64'(r_flag), 64'h0);

    do_in(1, 8'h41);
    chk("cap_ready1", 64'(dev_in_ready[1]), 64'h0);
    sel = 3'd1; cpu_ski = 1; cycle();
    chk("ski_skip", 64'(obs_skip), 64'h1);
    sel = 3'd1; cpu_inp = 1; cycle();
    chk("inp_rdata", 64'(obs_rdata), 64'h41);
    chk("inp_ready1", 64'(dev_in_ready[1]), 64'h1);

    do_out(0, 8'h5A);
    chk("out_valid0", 64'(dev_out_valid[0]), 64'h1);
    chk("out_data0", 64'(dev_out_data[7:0]), 64'h5A);
    sel = 3'd0; cpu_sko = 1; cycle();
    chk("sko_skip", 64'(obs_skip), 64'h0);
    dev_out_ack[0] = 1; cycle();
    chk("ack_valid0", 64'(dev_out_valid[0]), 64'h0);

    do_out(0, 8'h11);
    do_out(1, 8'h22);
    do_in(1, 8'h41);
    eval_r = 1; cycle();
    chk("noien_r", 64'(r_flag), 64'h0);
    cpu_ion = 1; cycle();
    eval_r = 1; cycle();
    chk("irq_r", 64'(r_flag), 64'h1);
    chk("irq_chan1", 64'(irq_chan), 64'h1);
    chk("irq_in", 64'(irq_is_out), 64'h0);
    r_ack = 1; cycle();
    chk("rack_r", 64'(r_flag), 64'h0);
    chk("rack_ien", 64'(ien), 64'h0);

    cpu_ion = 1; cpu_iof = 1; cycle();
    chk("ion_iof", 64'(ien), 64'h0);
    cpu_ion = 1; cycle();
    eval_r = 1; r_ack = 1; cycle();
    chk("rack_vs_set", 64'(r_flag), 64'h0);
    dev_out_ack[0] = 1; cycle();
    sel = 3'd0; cpu_out = 1; cpu_wdata = 8'h77; dev_out_ack[0] = 1; cycle();
    chk("out_ack_valid", 64'(dev_out_valid[0]), 64'h1);
    chk("out_ack_data", 64'(dev_out_data[7:0]), 64'h77);

    reset = 1; cycle();
    cpu_ion = 1; cycle();
    do_out(1, 8'h33);
    do_in(1, 8'h42);
    eval_r = 1; cycle();
    chk("prio1_chan", 64'(irq_chan), 64'h0);
    chk("prio1_out", 64'(irq_is_out), 64'h1);
    r_ack = 1; cycle();
    cpu_ion = 1; cycle();
    eval_r = 1; cycle();
`ifdef IO_INTR_RR_ARB_EN
    chk("prio2_chan", 64'(irq_chan), 64'h1);
    chk("prio2_out", 64'(irq_is_out), 64'h0);
`else
    chk("prio2_chan", 64'(irq_chan), 64'h0);
    chk("prio2_out", 64'(irq_is_out), 64'h1);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      dev_in_data  = (CH*DW)'($urandom);
      dev_in_valid = CH'($urandom);
      dev_out_ack  = CH'($urandom);
      sel          = CW'($urandom_range(0, 3));
      cpu_inp      = ($urandom_range(0, 3) == 0);
      cpu_out      = ($urandom_range(0, 3) == 0);
      cpu_ski      = ($urandom_range(0, 1) == 0);
      cpu_sko      = ($urandom_range(0, 1) == 0);
      cpu_ion      = ($urandom_range(0, 3) == 0);
      cpu_iof      = ($urandom_range(0, 7) == 0);
      cpu_wdata    = DW'($urandom);
      eval_r       = ($urandom_range(0, 1) == 0);
      r_ack        = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
